// File: rtl/hilo_md_unit.sv
// ---------------------------------------------------------------------------
// hilo_md_unit
//
// HI/LO multiply/divide unit for the EX stage. It executes MULT, MULTU, DIV,
// DIVU, MTHI, MTLO, MFHI and MFLO as issued by EX, owns the HI/LO
// architectural registers, and models a fixed multi-cycle latency. While an
// operation is in flight, busy/state tell the hazard unit to stall any
// dependent HiLo instruction.
//
// The result is computed at issue time and parked in holding registers. It
// is written to HI/LO only when the latency counter expires, and only if
// neither flush nor reset has aborted the operation in the meantime.
//
// Parameters
//   MULT_CYCLES : busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES  : busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk     in   1   clock, rising edge
//   reset   in   1   synchronous, active-low
//   flush   in   1   abort in-flight op; suppress issue/MT write this cycle
//   A       in  32   operand rs
//   B       in  32   operand rt
//   HiLoOp  in   4   0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                    5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9..15 NONE
//   C       out 32   HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   busy    out  1   registered; high while a mult/div is in flight
//   state   out  1   busy, or a mult/div presented while idle and not flushed
//   hi      out 32   current HI register
//   lo      out 32   current LO register
// ---------------------------------------------------------------------------
module hilo_md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  HiLoOp,
    output logic [31:0] C,
    output logic        busy,
    output logic        state,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ------------------------------------------------------------------
    // Operation encoding
    // ------------------------------------------------------------------
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fsm_t        fsm_q, fsm_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    // Result computed at issue, held until commit.
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    // Cleared for divide-by-zero so the commit edge leaves HI/LO untouched.
    logic        res_we_q, res_we_d;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic is_mult;
    logic is_div;
    logic is_md;
    logic is_signed_div;

    always_comb begin
        is_mult       = (HiLoOp == OP_MULT) || (HiLoOp == OP_MULTU);
        is_div        = (HiLoOp == OP_DIV)  || (HiLoOp == OP_DIVU);
        is_md         = is_mult || is_div;
        is_signed_div = (HiLoOp == OP_DIV);
    end

    // ------------------------------------------------------------------
    // Multiplier: both products computed at full 64-bit width.
    // ------------------------------------------------------------------
    logic [63:0] prod_u;
    logic [63:0] prod_s;

    always_comb begin
        prod_u = {32'd0, A} * {32'd0, B};
        prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
    end

    // ------------------------------------------------------------------
    // Divider: signed division is done on magnitudes and the signs are
    // reapplied afterwards. This keeps 0x80000000 / -1 well defined
    // (quotient wraps to 0x80000000, remainder 0) without depending on
    // the behaviour of a native signed divide on overflow.
    // ------------------------------------------------------------------
    logic        b_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;

    always_comb begin
        b_zero = (B == 32'd0);
        a_neg  = is_signed_div && A[31];
        b_neg  = is_signed_div && B[31];
        a_mag  = a_neg ? (~A + 32'd1) : A;
        b_mag  = b_neg ? (~B + 32'd1) : B;
        // Divisor forced to 1 on zero so the datapath never sees x/0; the
        // result is discarded through res_we anyway.
        if (b_zero) begin
            b_mag = 32'd1;
        end
        q_mag = a_mag / b_mag;
        r_mag = a_mag % b_mag;
        // Quotient is negative when operand signs differ; remainder takes
        // the sign of the dividend.
        div_q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        div_r = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_we_d = res_we_q;

        unique case (fsm_q)
            ST_IDLE: begin
                if (!flush) begin
                    if (is_md) begin
                        fsm_d = ST_RUN;
                        unique case (HiLoOp)
                            OP_MULT: begin
                                res_hi_d = prod_s[63:32];
                                res_lo_d = prod_s[31:0];
                                res_we_d = 1'b1;
                                cnt_d    = MULT_CNT;
                            end
                            OP_MULTU: begin
                                res_hi_d = prod_u[63:32];
                                res_lo_d = prod_u[31:0];
                                res_we_d = 1'b1;
                                cnt_d    = MULT_CNT;
                            end
                            default: begin
                                res_hi_d = div_r;
                                res_lo_d = div_q;
                                res_we_d = !b_zero;
                                cnt_d    = DIV_CNT;
                            end
                        endcase
                    end else if (HiLoOp == OP_MTHI) begin
                        hi_d = A;
                    end else if (HiLoOp == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end

            ST_RUN: begin
                // Every op presented while running is ignored here; the
                // upstream stall on state keeps this from happening.
                if (flush) begin
                    fsm_d = ST_IDLE;
                    cnt_d = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    fsm_d = ST_IDLE;
                    cnt_d = 4'd0;
                    if (res_we_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                fsm_d = ST_IDLE;
                cnt_d = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers (reset wins over flush and issue, and drops any pending
    // result)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q    <= ST_IDLE;
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_we_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_we_q <= res_we_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy  = (fsm_q == ST_RUN);
        // Stall request goes up in the issue cycle itself, before busy
        // has had a chance to register.
        state = busy || (!flush && is_md);
        hi    = hi_q;
        lo    = lo_q;
        C     = 32'd0;
        if (HiLoOp == OP_MFHI) begin
            C = hi_q;
        end else if (HiLoOp == OP_MFLO) begin
            C = lo_q;
        end
    end

endmodule

// File: doc/hilo_md_unit.md
Name: hilo_md_unit

Overview:
- Responder end of the EX-stage HiLoOp/busy/state interface: executes MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO issued by the EX stage.
- Owns the HI/LO architectural registers and models fixed multi-cycle latency.
- Raises state/busy so the hazard unit stalls dependent HiLo instructions.
- Sits beside the ALU in EX; its C output feeds the EX ALUout mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low; sampled on clk rising edge
- flush  input  1  abort the in-flight op and suppress any issue this cycle
- A  input  32  operand rs
- B  input  32  operand rt
- HiLoOp  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as NONE
- C  output  32  read data: HI for MFHI, LO for MFLO, else 0
- busy  output  1  registered; high while a mult/div is in progress
- state  output  1  combinational; busy OR (mult/div op presented while idle and flush low)
- hi  output  32  current HI register
- lo  output  32  current LO register

Behaviour:
- Reset (reset==0 at edge): hi=0, lo=0, busy=0, counter=0, latched operands=0. Reset has priority over flush and issue; it aborts an in-flight op and does not commit its result.
- C is combinational: MFHI->hi, MFLO->lo, otherwise 0. MFHI/MFLO read the current register value even while busy; the hazard unit must stall on state.
- FSM states:
  - IDLE (busy=0).
  - RUN (busy=1), with 4-bit down-counter cnt.
- IDLE -> RUN: at edge T when HiLoOp is in 1..4 and flush=0. At that edge:
  - latch the op and the result (signed/unsigned 64-bit product, or quotient/remainder).
  - set cnt = MULT_CYCLES or DIV_CYCLES, busy=1.
- RUN: each edge decrements cnt. At the edge where cnt==1, commit the latched result, set busy=0, return to IDLE.
  - busy is therefore high for exactly N cycles (T+1..T+N). The new hi/lo are visible from T+N+1.
- Any HiLoOp other than NONE presented while busy=1 is ignored: no issue, no MT write. Upstream stalls guarantee this never happens architecturally.
- MTHI/MTLO while idle and flush=0: hi (or lo) <= A at that edge, single cycle, busy stays 0.
- Mult results:
  - MULT: {hi,lo} = signed(A)*signed(B), 64-bit.
  - MULTU: {hi,lo} = unsigned product.
- Div results:
  - DIV: lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Div boundary cases:
  - B==0 for DIV or DIVU: busy runs the full DIV_CYCLES, then hi/lo stay unchanged. No exception is raised.
  - DIV with A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
- flush:
  - flush=1 while RUN: next edge busy=0, cnt=0, and the result is discarded; hi/lo are unchanged.
  - flush=1 on an issue cycle: no issue. MT writes are also suppressed.
  - flush=1 on the commit edge (cnt==1): the commit is discarded.
- state truth: state = busy | (~busy & ~flush & HiLoOp in 1..4).
- No back-to-back overlap: a new mult/div can be issued on the first cycle busy=0 after completion.

Test Plan:
- Reset low for 2 cycles, then MULT A=0xFFFFFFFD (-3), B=5 -> state=1 in the issue cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MFLO gives C=0xFFFFFFF1.
- MULTU A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU A=7, B=0 -> busy 10 cycles; hi/lo unchanged.
- MTHI A=0x12345678 while idle -> hi=0x12345678 next cycle, busy stays 0. Then issue DIV and present MTLO A=0xDEADBEEF during busy -> lo is not written by the MTLO.
- DIV A=100, B=7 with flush=1 on the 4th busy cycle -> busy=0 next cycle; hi/lo keep prior values. MULT presented with flush=1 -> state=0, no issue.
- With hi=lo=0, issue MULT 3*4 and drive reset=0 on the 3rd busy cycle -> next cycle busy=0, hi=lo=0, and the result is never committed.
